sha1_arb: RTL

//  Shares one sha1_dfa hashing engine among NREQ requesters (e.g. core MMIO port, DMA).

---
 rtl/sha1_arb_pkg.sv | 14 +
 rtl/sha1_arb_rr_arbiter.sv | 32 +++
 rtl/sha1_arb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sha1_arb_pkg.sv
// Shared widths and FSM encoding for the sha1_dfa request arbiter.
package sha1_arb_pkg;

  localparam int DIGEST_W = 160;
  localparam int WORD_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sha1_arb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  int             kk;
  logic [IDW-1:0] k;
  logic           hit;

  // Scan from farthest to nearest offset so the closest requester is written last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    kk    = 0;
    k     = '0;
    hit   = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      kk    = (int'(ptr) + i) % NREQ;
      k     = IDW'(kk);
      hit   = req[k];
      idx   = hit ? k : idx;
      valid = valid | hit;
    end
  end

endmodule

// File: rtl/sha1_arb.sv
// Round-robin front end sharing one sha1_dfa engine; sequences start, wait, latch, return.
module sha1_arb
  import sha1_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int IDW     = $clog2(NREQ),
  parameter int TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_i,
  input  logic [NREQ*WORD_W-1:0] para_i,
  input  logic [NREQ*WORD_W-1:0] addr_i,
  output logic [NREQ-1:0]        gnt_o,
  output logic [NREQ-1:0]        done_o,
  output logic [NREQ-1:0]        err_o,
  output logic [DIGEST_W-1:0]    result_o,
  output logic [IDW-1:0]         result_id_o,
  output logic                   eng_start_o,
  output logic [WORD_W-1:0]      eng_para_o,
  output logic [WORD_W-1:0]      eng_addr_o,
  input  logic [DIGEST_W-1:0]    eng_result_i,
  input  logic                   eng_ready_i,
  input  logic                   eng_busy_i,
  input  logic [WORD_W-1:0]      eng_addr_i
);

  localparam int CW = $clog2(TIMEOUT);

  state_t          state_r, state_nx;
  logic [IDW-1:0]  idx_r, rr_ptr_r, ptr_nx, arb_idx;
  logic            arb_valid, tag_hit, tag_fail;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] owner_oh, arb_oh;
  logic            unused_busy;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_i),
    .ptr   (rr_ptr_r),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign owner_oh    = NREQ'(1) << idx_r;
  assign arb_oh      = NREQ'(1) << arb_idx;
  assign unused_busy = eng_busy_i;

  // Next-state decode; a ready in the last counted cycle beats the timeout.
  always_comb begin
    state_nx = state_r;
    tag_hit  = 1'b0;
    tag_fail = 1'b0;
    ptr_nx   = (idx_r == IDW'(NREQ - 1)) ? '0 : idx_r + IDW'(1);
    case (state_r)
      ST_IDLE:  state_nx = arb_valid ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (eng_ready_i) begin
          if (eng_addr_i == eng_addr_o) begin
            tag_hit  = 1'b1;
            state_nx = ST_DONE;
          end else begin
            tag_fail = 1'b1;
            state_nx = ST_IDLE;
          end
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          tag_fail = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx;
  end

  // Job latches, handshake pulses and the cycle counter (counts from ISSUE).
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= '0;
      rr_ptr_r    <= '0;
      cnt_r       <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      err_o       <= '0;
      result_o    <= '0;
      result_id_o <= '0;
      eng_start_o <= 1'b0;
      eng_para_o  <= '0;
      eng_addr_o  <= '0;
    end else begin
      eng_start_o <= 1'b0;
      done_o      <= '0;
      err_o       <= '0;
      case (state_r)
        ST_IDLE: begin
          gnt_o <= '0;
          if (arb_valid) begin
            idx_r       <= arb_idx;
            eng_para_o  <= para_i[int'(arb_idx)*WORD_W +: WORD_W];
            eng_addr_o  <= addr_i[int'(arb_idx)*WORD_W +: WORD_W];
            eng_start_o <= 1'b1;
            gnt_o       <= arb_oh;
            cnt_r       <= '0;
          end
        end
        ST_ISSUE: cnt_r <= cnt_r + CW'(1);
        ST_WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (tag_hit) begin
            result_o    <= eng_result_i;
            result_id_o <= idx_r;
            done_o      <= owner_oh;
          end else if (tag_fail) begin
            err_o    <= owner_oh;
            rr_ptr_r <= ptr_nx;
          end
        end
        ST_DONE: begin
          gnt_o    <= '0;
          rr_ptr_r <= ptr_nx;
        end
        default: gnt_o <= '0;
      endcase
    end
  end

endmodule
